instruction_fetch_stage: RTL and testbench



---
 rtl/instruction_fetch_stage.sv | 76 +++++++
 tb/tb_instruction_fetch_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: fetch PC register, single-cycle imem handshake and IF/ID pipeline register.
// Redirect overrides stall, which overrides the memory handshake; bubbles carry NOP with valid=0.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTRUCTION = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_address,
    output logic        imem_request,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instruction_memory_data,
    output logic [31:0] program_counter,
    output logic        if_id_valid,
    output logic        fetch_state_o
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    fetch_state_e state_q;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  ifid_instr_q;
    logic [31:0]  ifid_pc_q;
    logic         ifid_valid_q;
    logic [31:0]  target_aligned;

    // Handshake: a fetch completes on any rising edge where imem_request and
    // imem_ready are both 1; the request drops whenever stall or redirect is high.
    assign target_aligned = {redirect_target[31:2], 2'b00};
    assign imem_request   = rst_n & ~stall & ~redirect;
    assign imem_address   = fetch_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_VECTOR;
            ifid_instr_q <= NOP_INSTRUCTION;
            ifid_pc_q    <= RESET_VECTOR;
            ifid_valid_q <= 1'b0;
        end else if (redirect) begin
            // Any response arriving alongside a redirect belongs to the wrong path.
            state_q      <= FETCH;
            fetch_pc_q   <= target_aligned;
            ifid_instr_q <= NOP_INSTRUCTION;
            ifid_pc_q    <= target_aligned;
            ifid_valid_q <= 1'b0;
        end else if (stall) begin
            state_q <= HOLD;
        end else begin
            state_q <= FETCH;
            if (imem_ready) begin
                ifid_instr_q <= imem_rdata;
                ifid_pc_q    <= fetch_pc_q;
                ifid_valid_q <= 1'b1;
                fetch_pc_q   <= fetch_pc_q + 32'd4;
            end else begin
                ifid_instr_q <= NOP_INSTRUCTION;
                ifid_pc_q    <= fetch_pc_q;
                ifid_valid_q <= 1'b0;
            end
        end
    end

    assign instruction_memory_data = ifid_instr_q;
    assign program_counter         = ifid_pc_q;
    assign if_id_valid             = ifid_valid_q;
    assign fetch_state_o           = state_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage: reset, streaming fetch, wait states,
// stall, redirect under stall, PC wrap and asynchronous reset mid-wait.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RV  = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_address;
    logic        imem_request;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instruction_memory_data;
    logic [31:0] program_counter;
    logic        if_id_valid;
    logic        fetch_state_o;

    int n_cmp  = 0;
    int n_fail = 0;

    instruction_fetch_stage #(
        .RESET_VECTOR   (RV),
        .NOP_INSTRUCTION(NOP)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .stall                  (stall),
        .redirect               (redirect),
        .redirect_target        (redirect_target),
        .imem_address           (imem_address),
        .imem_request           (imem_request),
        .imem_rdata             (imem_rdata),
        .imem_ready             (imem_ready),
        .instruction_memory_data(instruction_memory_data),
        .program_counter        (program_counter),
        .if_id_valid            (if_id_valid),
        .fetch_state_o          (fetch_state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                              input logic v);
        check({tag, ".instr"}, instruction_memory_data, ins);
        check({tag, ".pc"}, program_counter, pc);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        imem_rdata      = 32'h0;
        imem_ready      = 1'b0;
        #12;
        check("rst.addr", imem_address, RV);
        check("rst.req", {31'd0, imem_request}, 32'd0);
        check_ifid("rst.ifid", NOP, RV, 1'b0);

        // Streaming fetch with zero-wait memory
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'h0050_0093;
        #1;
        check("s0.addr", imem_address, 32'h0);
        check("s0.req", {31'd0, imem_request}, 32'd1);
        tick();
        check_ifid("s1.ifid", 32'h0050_0093, 32'h0, 1'b1);
        check("s1.addr", imem_address, 32'h4);
        imem_rdata = 32'h00A0_0113;
        tick();
        check_ifid("s2.ifid", 32'h00A0_0113, 32'h4, 1'b1);
        check("s2.addr", imem_address, 32'h8);

        // Three wait cycles at 0x8
        imem_ready = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("w.addr", imem_address, 32'h8);
            check_ifid("w.ifid", NOP, 32'h8, 1'b0);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0033;
        tick();
        check_ifid("w3.ifid", 32'h0000_0033, 32'h8, 1'b1);
        check("w3.addr", imem_address, 32'hC);

        // Two stall cycles at 0xC; memory offers data that must be ignored
        stall      = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("st.req", {31'd0, imem_request}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("st.addr", imem_address, 32'hC);
            check_ifid("st.ifid", 32'h0000_0033, 32'h8, 1'b1);
            check("st.state", {31'd0, fetch_state_o}, 32'd1);
        end
        stall      = 1'b0;
        imem_rdata = 32'h1111_1111;
        tick();
        check_ifid("st2.ifid", 32'h1111_1111, 32'hC, 1'b1);
        check("st2.addr", imem_address, 32'h10);
        check("st2.state", {31'd0, fetch_state_o}, 32'd0);

        // Redirect concurrent with stall, misaligned target
        redirect        = 1'b1;
        stall           = 1'b1;
        redirect_target = 32'h0000_0102;
        imem_rdata      = 32'h2222_2222;
        #1;
        check("rd.req", {31'd0, imem_request}, 32'd0);
        tick();
        check("rd.addr", imem_address, 32'h100);
        check_ifid("rd.ifid", NOP, 32'h100, 1'b0);
        check("rd.state", {31'd0, fetch_state_o}, 32'd0);
        redirect   = 1'b0;
        stall      = 1'b0;
        imem_rdata = 32'h3333_3333;
        tick();
        check_ifid("rd2.ifid", 32'h3333_3333, 32'h100, 1'b1);
        check("rd2.addr", imem_address, 32'h104);

        // Wrap from 0xFFFF_FFFC
        redirect        = 1'b1;
        redirect_target = 32'hFFFF_FFFF;
        tick();
        check("wr.addr", imem_address, 32'hFFFF_FFFC);
        redirect   = 1'b0;
        imem_rdata = 32'h4444_4444;
        tick();
        check_ifid("wr2.ifid", 32'h4444_4444, 32'hFFFF_FFFC, 1'b1);
        check("wr2.addr", imem_address, 32'h0);

        // Asynchronous reset in the middle of a wait at 0x40
        redirect        = 1'b1;
        redirect_target = 32'h0000_0040;
        tick();
        redirect   = 1'b0;
        imem_ready = 1'b0;
        tick();
        check("ar.addr", imem_address, 32'h40);
        check_ifid("ar.ifid", NOP, 32'h40, 1'b0);
        imem_ready = 1'b1;
        imem_rdata = 32'h5555_5555;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.rst.addr", imem_address, RV);
        check("ar.rst.req", {31'd0, imem_request}, 32'd0);
        check_ifid("ar.rst.ifid", NOP, RV, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        check("ar.rel.addr", imem_address, RV);
        check("ar.rel.req", {31'd0, imem_request}, 32'd1);
        tick();
        check_ifid("ar2.ifid", 32'h5555_5555, RV, 1'b1);
        check("ar2.addr", imem_address, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
